// File: rtl/mem_bank_pipe.sv
// mem_bank_pipe: single-port synchronous RAM with per-byte write enables,
// a configurable read latency (RD_LAT = 1..4 register stages from the accept
// edge to valid_out) and a hardware self-clear that runs after every reset.
//
// Optional build macro PARITY_EN: when defined, each byte carries a stored
// even-parity bit (inj_par inverts it on write) and parity_err flags a
// mismatching read word. When undefined, there is no parity storage,
// inj_par is ignored and parity_err stays 0.
//
// DATA_W must be a multiple of 8.
module mem_bank_pipe #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  EN,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     add,
    input  logic [DATA_W-1:0]     Data_in,
    input  logic [DATA_W/8-1:0]   byte_en,
    input  logic                  inj_par,
    output logic                  valid_out,
    output logic [DATA_W-1:0]     Data_out,
    output logic                  init_done,
    output logic                  err,
    output logic                  parity_err
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int PW    = RD_LAT - 1;   // extra stages behind the RAM output register

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              ram_vld_q, ram_vld_d;

    logic              req;
    logic              init_we;
    logic              acc_wr;
    logic              acc_rd;
    logic [ADDR_W-1:0] wr_addr;

    logic [DATA_W-1:0] ram_rd_data;
    logic [NB-1:0]     lane_perr;
    logic              ram_perr;

    logic              last_vld;
    logic [DATA_W-1:0] last_data;
    logic              last_perr;

    // Request qualification: INIT owns the write port, RUN services EN requests.
    // Nothing is written or accepted on a reset edge.
    always_comb begin
        req     = EN & (wr_en | rd_en);
        init_we = (state_q == ST_INIT) & ~rst;
        acc_wr  = (state_q == ST_RUN) & ~rst & EN & wr_en;
        acc_rd  = (state_q == ST_RUN) & ~rst & EN & rd_en;
        wr_addr = init_we ? cnt_q : add;
    end

    // Next-state logic: INIT sweeps every address once, then RUN forever.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        ram_vld_d = acc_rd;
        case (state_q)
            ST_INIT: begin
                err_d = req;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Control registers; reset restarts the clear and drops any read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            ram_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ram_vld_q <= ram_vld_d;
        end
    end

    // One narrow RAM per byte lane so each byte enable maps onto its own
    // write port; the registered read is the first latency stage.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_q;
            logic       we;
            logic [7:0] wdata;

            assign we    = init_we | (acc_wr & byte_en[gi]);
            assign wdata = init_we ? 8'h00 : Data_in[8*gi +: 8];

            // Read-first port: a same-edge write is not visible to the read.
            always_ff @(posedge clk) begin
                if (we) begin
                    mem[wr_addr] <= wdata;
                end
                if (rst) begin
                    rd_q <= 8'h00;
                end else if (acc_rd) begin
                    rd_q <= mem[add];
                end
            end

            assign ram_rd_data[8*gi +: 8] = rd_q;

`ifdef PARITY_EN
            logic par_mem [DEPTH];
            logic par_rd_q;
            logic wpar;

            // Even parity of the byte; injection only applies to user writes.
            assign wpar = (^wdata) ^ (inj_par & ~init_we);

            // Parity bit shadows the data byte with the same read-first timing.
            always_ff @(posedge clk) begin
                if (we) begin
                    par_mem[wr_addr] <= wpar;
                end
                if (rst) begin
                    par_rd_q <= 1'b0;
                end else if (acc_rd) begin
                    par_rd_q <= par_mem[add];
                end
            end

            assign lane_perr[gi] = (^rd_q) ^ par_rd_q;
`else
            assign lane_perr[gi] = 1'b0;
`endif
        end
    endgenerate

`ifndef PARITY_EN
    logic unused_inj_par;
    assign unused_inj_par = inj_par;
`endif

    assign ram_perr = |lane_perr;

    // Remaining latency stages. Each data stage only loads behind a valid
    // beat, so the last stage naturally holds the previous read result.
    generate
        if (RD_LAT == 1) begin : g_lat1
            assign last_vld  = ram_vld_q;
            assign last_data = ram_rd_data;
            assign last_perr = ram_perr;
        end else begin : g_dly
            logic [DATA_W-1:0] dly_data_q [PW];
            logic [DATA_W-1:0] dly_data_d [PW];
            logic [PW-1:0]     dly_vld_q,  dly_vld_d;
            logic [PW-1:0]     dly_perr_q, dly_perr_d;

            // Shift valid every cycle; move data/parity flag only with a valid beat.
            always_comb begin
                dly_vld_d     = PW'({dly_vld_q, ram_vld_q});
                dly_data_d[0] = ram_vld_q ? ram_rd_data : dly_data_q[0];
                dly_perr_d    = dly_perr_q;
                dly_perr_d[0] = ram_vld_q ? ram_perr : dly_perr_q[0];
                for (int k = 1; k < PW; k++) begin
                    dly_data_d[k] = dly_vld_q[k-1] ? dly_data_q[k-1] : dly_data_q[k];
                    dly_perr_d[k] = dly_vld_q[k-1] ? dly_perr_q[k-1] : dly_perr_q[k];
                end
            end

            // Pipeline registers; reset flushes beats and zeroes the held word.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dly_vld_q  <= '0;
                    dly_perr_q <= '0;
                    for (int k = 0; k < PW; k++) begin
                        dly_data_q[k] <= '0;
                    end
                end else begin
                    dly_vld_q  <= dly_vld_d;
                    dly_perr_q <= dly_perr_d;
                    for (int k = 0; k < PW; k++) begin
                        dly_data_q[k] <= dly_data_d[k];
                    end
                end
            end

            assign last_vld  = dly_vld_q[PW-1];
            assign last_data = dly_data_q[PW-1];
            assign last_perr = dly_perr_q[PW-1];
        end
    endgenerate

    assign valid_out  = last_vld;
    assign Data_out   = last_data;
    assign parity_err = last_vld & last_perr;
    assign init_done  = (state_q == ST_RUN);
    assign err        = err_q;

endmodule
